// File: rtl/card_draw_arbiter.sv
// card_draw_arbiter: shares one VGA pixel-plot port among NREQ box-fill
// requesters. Grants round-robin, latches the winner's origin and colour,
// then sweeps a 2^SIZE_LOG2 square one pixel per clock, row-major.
// Optional build macro ABORT_EN: dropping req[grant] during DRAW abandons
// the box without a done pulse.
module card_draw_arbiter #(
  parameter int NREQ      = 4,
  parameter int SIZE_LOG2 = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] x0_flat,
  input  logic [7*NREQ-1:0] y0_flat,
  input  logic [3*NREQ-1:0] colour_flat,
  output logic [7:0]        x,
  output logic [6:0]        y,
  output logic [2:0]        colour,
  output logic              plot,
  output logic [NREQ-1:0]   done,
  output logic              busy
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = 2 * SIZE_LOG2;

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

  state_t          state, state_next;
  logic [GW-1:0]   rr_ptr;
  logic [GW-1:0]   grant;
  logic [GW-1:0]   pick;
  logic            pick_valid;
  logic [CW-1:0]   count;
  logic [7:0]      bx;
  logic [6:0]      by;
  logic [2:0]      bcol;
  logic            abort;

  // Requester index base+step, wrapped modulo NREQ (step < NREQ).
  function automatic logic [GW-1:0] wrap_inc(input logic [GW-1:0] base, input int step);
    int sum;
    sum = int'(base) + step;
    if (sum >= NREQ) sum = sum - NREQ;
    return GW'(sum);
  endfunction

  // Round-robin search: first set req bit at or above rr_ptr, wrapping.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    pick       = '0;
    pick_valid = 1'b0;
    // Walk downward so the closest candidate to rr_ptr is assigned last and wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[wrap_inc(rr_ptr, k)]) begin
        pick       = wrap_inc(rr_ptr, k);
        pick_valid = 1'b1;
      end
    end
  end

`ifdef ABORT_EN
  assign abort = (state == S_DRAW) && !req[grant];
`else
  assign abort = 1'b0;
`endif

  // Next-state logic for the IDLE -> DRAW -> DONE sequence.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: if (pick_valid) state_next = S_DRAW;
      S_DRAW: begin
        if (abort)       state_next = S_IDLE;
        else if (&count) state_next = S_DONE;
      end
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    else          state <= state_next;
  end

  // Datapath: grant latch, pixel sweep, registered VGA outputs and done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: every datapath register is reset; there is no memory here, so nothing is left uninitialised.
      rr_ptr <= '0;
      grant  <= '0;
      count  <= '0;
      bx     <= '0;
      by     <= '0;
      bcol   <= '0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
      done   <= '0;
    end else begin
      plot <= 1'b0;
      done <= '0;
      unique case (state)
        S_IDLE: begin
          if (pick_valid) begin
            grant <= pick;
            bx    <= x0_flat[8*pick +: 8];
            by    <= y0_flat[7*pick +: 7];
            bcol  <= colour_flat[3*pick +: 3];
            count <= '0;
          end
        end
        S_DRAW: begin
          if (abort) begin
            rr_ptr <= wrap_inc(grant, 1);
          end else begin
            plot   <= 1'b1;
            x      <= bx + 8'(count[SIZE_LOG2-1:0]);
            y      <= by + 7'(count[CW-1:SIZE_LOG2]);
            colour <= bcol;
            count  <= count + CW'(1);
          end
        end
        S_DONE: begin
          done[grant] <= 1'b1;
          rr_ptr      <= wrap_inc(grant, 1);
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_card_draw_arbiter.sv
// Self-checking bench for card_draw_arbiter: directed scenarios plus random
// requests, checked against a box-level reference model (round-robin pick
// and arithmetic pixel coordinates).
module tb_card_draw_arbiter;

  localparam int NREQ = 4;
  localparam int SIDE = 16;
  localparam int PIX  = SIDE * SIDE;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] x0_flat;
  logic [7*NREQ-1:0] y0_flat;
  logic [3*NREQ-1:0] colour_flat;
  logic [7:0]        x;
  logic [6:0]        y;
  logic [2:0]        colour;
  logic              plot;
  logic [NREQ-1:0]   done;
  logic              busy;

  logic [7:0] x0_arr  [NREQ];
  logic [6:0] y0_arr  [NREQ];
  logic [2:0] col_arr [NREQ];

  int checks = 0;
  int errors = 0;
  int rr     = 0;   // model's round-robin pointer

  card_draw_arbiter #(.NREQ(NREQ), .SIZE_LOG2(4)) dut (
    .clk(clk), .reset_n(reset_n), .req(req),
    .x0_flat(x0_flat), .y0_flat(y0_flat), .colour_flat(colour_flat),
    .x(x), .y(y), .colour(colour), .plot(plot), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    x0_flat     = '0;
    y0_flat     = '0;
    colour_flat = '0;
    for (int i = 0; i < NREQ; i++) begin
      x0_flat[8*i +: 8]     = x0_arr[i];
      y0_flat[7*i +: 7]     = y0_arr[i];
      colour_flat[3*i +: 3] = col_arr[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference round-robin: first requester at or above ptr, wrapping.
  function automatic int winner(input logic [NREQ-1:0] r, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Serves one box from IDLE: grant edge, stop_after pixel edges, then the
  // done edge when the box is complete. drop_mid releases req[winner] after
  // pixel 50 (abandons the box only in an ABORT_EN build).
  task automatic draw_box(input int stop_after, input bit drop_mid);
    int w;
    logic [7:0] bx;
    logic [6:0] by;
    logic [2:0] bc;
    w = winner(req, rr);
    if (w < 0) begin
      check("winner_exists", 32'(w), 32'(0));
      return;
    end
    bx = x0_arr[w];
    by = y0_arr[w];
    bc = col_arr[w];
    cycle();
    check($sformatf("grant_req%0d", w), {busy, plot, done}, {1'b1, 1'b0, {NREQ{1'b0}}});
    // Inputs change after grant; the box in progress must not follow them.
    x0_arr[w]  = 8'($urandom);
    y0_arr[w]  = 7'($urandom);
    col_arr[w] = 3'($urandom);
    for (int i = 0; i < stop_after; i++) begin
      cycle();
      check($sformatf("pixel%0d_req%0d", i, w), {plot, x, y, colour},
            {1'b1, bx + 8'(i % SIDE), by + 7'(i / SIDE), bc});
      if (drop_mid && i == 49) begin
        req[w] = 1'b0;
`ifdef ABORT_EN
        cycle();
        check("abort_plot_low", {plot, done}, '0);
        rr = (w + 1) % NREQ;
        return;
`endif
      end
    end
    if (stop_after < PIX) return;
    cycle();
    check($sformatf("done_req%0d", w), {plot, busy, done}, {1'b0, 1'b0, NREQ'(1 << w)});
    rr = (w + 1) % NREQ;
  endtask

  initial begin
    reset_n = 1'b0;
    req     = '0;
    for (int i = 0; i < NREQ; i++) begin
      x0_arr[i] = '0; y0_arr[i] = '0; col_arr[i] = '0;
    end

    // Reset state.
    repeat (2) cycle();
    check("reset_xy", {x, y, colour}, '0);
    check("reset_ctl", {plot, done, busy}, '0);
    reset_n = 1'b1;
    rr = 0;

    // No request: stays idle.
    cycle();
    check("idle_no_req", {plot, busy, done}, '0);

    // Single request, directed origin.
    x0_arr[0] = 8'd10; y0_arr[0] = 7'd20; col_arr[0] = 3'b101;
    req = 4'b0001;
    draw_box(PIX, 1'b0);
    req = 4'b0000;
    cycle();
    check("idle_after_single", {plot, busy, done}, '0);

    // Simultaneous requests from a fresh reset: 0 then 2, back to back.
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    rr = 0;
    x0_arr[0] = 8'd40;  y0_arr[0] = 7'd5;  col_arr[0] = 3'b001;
    x0_arr[2] = 8'd100; y0_arr[2] = 7'd60; col_arr[2] = 3'b110;
    req = 4'b0101;
    draw_box(PIX, 1'b0);
    req[0] = 1'b0;
    draw_box(PIX, 1'b0);

    // Round-robin fairness with two requests held continuously.
    req = 4'b0011;
    repeat (4) draw_box(PIX, 1'b0);

    // Coordinate wrap in both axes.
    req = 4'b0010;
    x0_arr[1] = 8'd250; y0_arr[1] = 7'd120; col_arr[1] = 3'b011;
    draw_box(PIX, 1'b0);

    // Reset mid-DRAW after pixel 100: outputs drop at once.
    req = 4'b0100;
    draw_box(100, 1'b0);
    reset_n = 1'b0;
    #1;
    check("midreset_ctl", {plot, busy, done}, '0);
    check("midreset_xy", {x, y, colour}, '0);
    req = 4'b1010;
    cycle();
    reset_n = 1'b1;
    rr = 0;
    draw_box(PIX, 1'b0);

    // Drop req mid-box with req[3] pending.
    req = 4'b1000;
    draw_box(PIX, 1'b0);
    req = 4'b1001;
    draw_box(PIX, 1'b1);
    draw_box(PIX, 1'b0);

    // Random requests and origins.
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        x0_arr[i] = 8'($urandom); y0_arr[i] = 7'($urandom); col_arr[i] = 3'($urandom);
      end
      req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      draw_box(PIX, 1'b0);
    end

    req = '0;
    cycle();
    check("final_idle", {plot, busy, done}, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
